// File: rtl/shufflenetv2_udiv_seq.sv
// shufflenetv2_udiv_seq: sequential unsigned restoring divider.
// One operation in flight, valid/ready on both the operand and result sides.
// Divide-by-zero and quotient overflow are detected when the operands are
// accepted and complete without iterating. A normal divide produces one
// quotient bit per cycle, MSB first.
// Optional build macro: SHUFFLENETV2_UDIV_ROUND_EN rounds normal-path quotients
// to nearest. The remainder stays the floor remainder, and the quotient
// saturates with ovf set if the increment would wrap.
// DIVIDEND_W must equal DIVISOR_W + QUOT_W.
module shufflenetv2_udiv_seq #(
   parameter int DIVIDEND_W = 22,
   parameter int DIVISOR_W  = 10,
   parameter int QUOT_W     = 12
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [QUOT_W-1:0]     quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  ovf,
   output logic                  dz
);

   localparam int CNT_W = $clog2(QUOT_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

`ifdef SHUFFLENETV2_UDIV_ROUND_EN
   // Round to nearest. Returns {ovf, quotient}; all-ones saturates instead of wrapping.
   function automatic logic [QUOT_W:0] round_nearest(
      input logic [QUOT_W-1:0]    q,
      input logic [DIVISOR_W-1:0] r,
      input logic [DIVISOR_W-1:0] d
   );
      logic round_up;
      round_up = ({r, 1'b0} >= {1'b0, d});
      if (!round_up) begin
         round_nearest = {1'b0, q};
      end else if (&q) begin
         round_nearest = {1'b1, q};
      end else begin
         round_nearest = {1'b0, q + {{(QUOT_W-1){1'b0}}, 1'b1}};
      end
   endfunction
`endif

   state_t                 state_q, state_d;
   logic [DIVISOR_W:0]     rem_q, rem_d;     // partial remainder
   logic [QUOT_W-1:0]      shf_q, shf_d;     // dividend low bits out, quotient bits in
   logic [DIVISOR_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [QUOT_W-1:0]      quot_q, quot_d;
   logic [DIVISOR_W-1:0]   rmd_q, rmd_d;
   logic                   ovf_q, ovf_d;
   logic                   dz_q, dz_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;

   logic                   accept_s;
   logic [DIVISOR_W-1:0]   hi_s;
   logic [DIVISOR_W+1:0]   trial_s;
   logic                   ge_s;
   logic [DIVISOR_W:0]     diff_s;
   logic [DIVISOR_W:0]     rem_nxt_s;
   logic [QUOT_W-1:0]      shf_nxt_s;
   logic [QUOT_W-1:0]      fin_q_s;
   logic                   fin_ovf_s;

   assign accept_s = in_valid & in_ready_q;
   assign hi_s     = dividend[DIVIDEND_W-1:QUOT_W];

   // One restoring step: shift in the next dividend bit, then subtract if it fits.
   always_comb begin
      trial_s   = {rem_q, shf_q[QUOT_W-1]};
      ge_s      = (trial_s >= {2'b00, div_q});
      diff_s    = trial_s[DIVISOR_W:0] - {1'b0, div_q};
      rem_nxt_s = ge_s ? diff_s : trial_s[DIVISOR_W:0];
      shf_nxt_s = {shf_q[QUOT_W-2:0], ge_s};
`ifdef SHUFFLENETV2_UDIV_ROUND_EN
      {fin_ovf_s, fin_q_s} = round_nearest(shf_nxt_s, rem_nxt_s[DIVISOR_W-1:0], div_q);
`else
      fin_ovf_s = 1'b0;
      fin_q_s   = shf_nxt_s;
`endif
   end

   // Next-state and next-output logic for the IDLE/CALC/DONE controller.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      shf_d       = shf_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      quot_d      = quot_q;
      rmd_d       = rmd_q;
      ovf_d       = ovf_q;
      dz_d        = dz_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               in_ready_d = 1'b0;
               div_d      = divisor;
               if (divisor == {DIVISOR_W{1'b0}}) begin
                  state_d     = ST_DONE;
                  quot_d      = {QUOT_W{1'b1}};
                  rmd_d       = dividend[DIVISOR_W-1:0];
                  ovf_d       = 1'b0;
                  dz_d        = 1'b1;
                  out_valid_d = 1'b1;
               end else if (hi_s >= divisor) begin
                  state_d     = ST_DONE;
                  quot_d      = {QUOT_W{1'b1}};
                  rmd_d       = {DIVISOR_W{1'b0}};
                  ovf_d       = 1'b1;
                  dz_d        = 1'b0;
                  out_valid_d = 1'b1;
               end else begin
                  state_d = ST_CALC;
                  rem_d   = {1'b0, hi_s};
                  shf_d   = dividend[QUOT_W-1:0];
                  cnt_d   = {CNT_W{1'b0}};
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            rem_d = rem_nxt_s;
            shf_d = shf_nxt_s;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_W'(QUOT_W-1)) begin
               state_d     = ST_DONE;
               quot_d      = fin_q_s;
               rmd_d       = rem_nxt_s[DIVISOR_W-1:0];
               ovf_d       = fin_ovf_s;
               dz_d        = 1'b0;
               out_valid_d = 1'b1;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // Controller state and all registered outputs; reset abandons any operation.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q     <= ST_IDLE;
         rem_q       <= {(DIVISOR_W+1){1'b0}};
         shf_q       <= {QUOT_W{1'b0}};
         div_q       <= {DIVISOR_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         quot_q      <= {QUOT_W{1'b0}};
         rmd_q       <= {DIVISOR_W{1'b0}};
         ovf_q       <= 1'b0;
         dz_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         shf_q       <= shf_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         quot_q      <= quot_d;
         rmd_q       <= rmd_d;
         ovf_q       <= ovf_d;
         dz_q        <= dz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quot_q;
   assign remainder = rmd_q;
   assign ovf       = ovf_q;
   assign dz        = dz_q;

endmodule

// File: tb/tb_shufflenetv2_udiv_seq.sv
// Self-checking bench for shufflenetv2_udiv_seq at default parameters.
// Directed vector table, stall / reset sequences, randomized operands vs. an
// arithmetic reference model. Honors SHUFFLENETV2_UDIV_ROUND_EN if defined.
module tb_shufflenetv2_udiv_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [21:0] dividend;
   logic [9:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] quotient;
   logic [9:0]  remainder;
   logic        ovf;
   logic        dz;

   shufflenetv2_udiv_seq dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf),
      .dz        (dz)
   );

   always #5 ap_clk = ~ap_clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] res_q;
   logic [9:0]  res_r;
   logic        res_ovf;
   logic        res_dz;
   int          res_lat;

   typedef struct {
      logic [21:0] a;
      logic [9:0]  b;
      logic [11:0] q;
      logic [9:0]  r;
      logic        o;
      logic        z;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic from the block's rules.
   function automatic void model(input longint a, input longint b,
                                 output longint q, output longint r,
                                 output longint o, output longint z,
                                 output longint lat);
      if (b == 0) begin
         q = 4095; r = a % 1024; o = 0; z = 1; lat = 1;
      end else if ((a / 4096) >= b) begin
         q = 4095; r = 0; o = 1; z = 0; lat = 1;
      end else begin
         q = a / b; r = a % b; o = 0; z = 0; lat = 13;
`ifdef SHUFFLENETV2_UDIV_ROUND_EN
         if (2 * r >= b) begin
            if (q == 4095) o = 1;
            else q = q + 1;
         end
`endif
      end
   endfunction

   task automatic run_op(input logic [21:0] a, input logic [9:0] b);
      int g;
      g = 0;
      while (!in_ready && g < 64) begin
         @(negedge ap_clk);
         g++;
      end
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      in_valid = 1'b0;
      res_lat  = 1;
      while (!out_valid && res_lat < 64) begin
         @(negedge ap_clk);
         res_lat++;
      end
      res_q   = quotient;
      res_r   = remainder;
      res_ovf = ovf;
      res_dz  = dz;
      out_ready = 1'b1;
      @(negedge ap_clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint eq, er, eo, ez, el;
      logic [21:0] ra;
      logic [9:0]  rb;
      logic [11:0] hq;
      logic [9:0]  hr;
      int          seen;
      int          mode;
      longint      qq, rr;

      // Directed vectors: {dividend, divisor, quotient, remainder, ovf, dz, latency}
`ifdef SHUFFLENETV2_UDIV_ROUND_EN
      vecs.push_back('{22'd1000,    10'd7,    12'd143,  10'd6,    1'b0, 1'b0, 13});
      vecs.push_back('{22'd4190207, 10'd1023, 12'd4095, 10'd1022, 1'b1, 1'b0, 13});
      vecs.push_back('{22'd101,     10'd3,    12'd34,   10'd2,    1'b0, 1'b0, 13});
`else
      vecs.push_back('{22'd1000,    10'd7,    12'd142,  10'd6,    1'b0, 1'b0, 13});
      vecs.push_back('{22'd4190207, 10'd1023, 12'd4095, 10'd1022, 1'b0, 1'b0, 13});
      vecs.push_back('{22'd101,     10'd3,    12'd33,   10'd2,    1'b0, 1'b0, 13});
`endif
      vecs.push_back('{22'd4189185, 10'd1023, 12'd4095, 10'd0,    1'b0, 1'b0, 13});
      vecs.push_back('{22'd4190208, 10'd1023, 12'd4095, 10'd0,    1'b1, 1'b0, 1});
      vecs.push_back('{22'd500,     10'd0,    12'd4095, 10'd500,  1'b0, 1'b1, 1});
      vecs.push_back('{22'd84,      10'd4,    12'd21,   10'd0,    1'b0, 1'b0, 13});
      vecs.push_back('{22'd0,       10'd5,    12'd0,    10'd0,    1'b0, 1'b0, 13});
      vecs.push_back('{22'd4095,    10'd1,    12'd4095, 10'd0,    1'b0, 1'b0, 13});
      vecs.push_back('{22'd4194303, 10'd1,    12'd4095, 10'd0,    1'b1, 1'b0, 1});
      vecs.push_back('{22'd100,     10'd3,    12'd33,   10'd1,    1'b0, 1'b0, 13});
      vecs.push_back('{22'd4194303, 10'd0,    12'd4095, 10'd1023, 1'b0, 1'b1, 1});

      ap_rst_n  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = 22'd0;
      divisor   = 10'd0;
      @(posedge ap_clk);
      @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;

      // Reset state
      check("rst_in_ready",  in_ready,  1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient",  quotient,  0);
      check("rst_remainder", remainder, 0);
      check("rst_ovf",       ovf,       0);
      check("rst_dz",        dz,        0);

      // Directed table
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].a, vecs[i].b);
         check($sformatf("vec%0d_q", i),   res_q,   vecs[i].q);
         check($sformatf("vec%0d_r", i),   res_r,   vecs[i].r);
         check($sformatf("vec%0d_ovf", i), res_ovf, vecs[i].o);
         check($sformatf("vec%0d_dz", i),  res_dz,  vecs[i].z);
         check($sformatf("vec%0d_lat", i), res_lat, vecs[i].lat);
         check($sformatf("vec%0d_rdy", i), in_ready, 1);
      end

      // Back-pressure: result held for 20 cycles, extra operands ignored
      dividend = 22'd1000;
      divisor  = 10'd7;
      in_valid = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      in_valid = 1'b0;
      seen = 0;
      while (!out_valid && seen < 64) begin
         @(negedge ap_clk);
         seen++;
      end
      check("stall_valid", out_valid, 1);
      for (int i = 0; i < 20; i++) begin
         dividend = 22'd84;
         divisor  = 10'd4;
         in_valid = 1'b1;
         @(negedge ap_clk);
`ifdef SHUFFLENETV2_UDIV_ROUND_EN
         check("stall_q", quotient, 143);
`else
         check("stall_q", quotient, 142);
`endif
         check("stall_r",     remainder, 6);
         check("stall_ovf",   ovf,       0);
         check("stall_dz",    dz,        0);
         check("stall_rdy",   in_ready,  0);
         check("stall_valid", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge ap_clk);
      out_ready = 1'b0;
      check("pop_rdy",   in_ready,  1);
      check("pop_valid", out_valid, 0);
      seen = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge ap_clk);
         if (out_valid) seen++;
      end
      check("ignored_op_no_result", seen, 0);

      // Reset in the middle of a divide
      dividend = 22'd1000;
      divisor  = 10'd7;
      in_valid = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge ap_clk);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_q",     quotient,  0);
      check("mid_rst_r",     remainder, 0);
      check("mid_rst_ovf",   ovf,       0);
      check("mid_rst_dz",    dz,        0);
      check("mid_rst_rdy",   in_ready,  1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge ap_clk);
         if (out_valid) seen++;
      end
      check("mid_rst_no_result", seen, 0);
      run_op(22'd84, 10'd4);
      check("post_rst_q",   res_q,   21);
      check("post_rst_r",   res_r,   0);
      check("post_rst_lat", res_lat, 13);

      // Randomized operands against the reference model
      for (int i = 0; i < 2000; i++) begin
         mode = $urandom_range(0, 9);
         if (mode < 8) begin
            rb = 10'($urandom_range(1, 1023));
            qq = $urandom_range(0, 4095);
            rr = $urandom_range(0, int'(rb) - 1);
            ra = 22'(qq * rb + rr);
         end else begin
            ra = 22'($urandom_range(0, 4194303));
            rb = (mode == 9) ? 10'd0 : 10'($urandom_range(1, 1023));
         end
         model(ra, rb, eq, er, eo, ez, el);
         run_op(ra, rb);
         hq = res_q;
         hr = res_r;
         check("rnd_q",   hq,      eq);
         check("rnd_r",   hr,      er);
         check("rnd_ovf", res_ovf, eo);
         check("rnd_dz",  res_dz,  ez);
         check("rnd_lat", res_lat, el);
`ifndef SHUFFLENETV2_UDIV_ROUND_EN
         if (ez == 0 && eo == 0) begin
            check("rnd_identity", longint'(hq) * rb + hr, ra);
            check("rnd_rem_lt_div", (hr < rb) ? 1 : 0, 1);
         end
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
